// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the async FIFO (rd_clk domain).
// Pops words from the FIFO read port and re-presents them as a valid/ready
// stream through a 2-entry buffer with credit-based prefetch.
// Optional feature macro: FIFO_RD_PKT_EN (per-word m_last generation).
module fifo_rd_stream #(
    parameter int D_WIDTH = 8,
    parameter int PKT_LEN = 4
) (
    input  logic               rd_clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [D_WIDTH-1:0] fifo_rd_data,
    output logic               fifo_rd_en,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_last
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t               occ, occ_next;
    logic               inflight;
    logic               pop;
    logic [1:0]         credit;
    logic               wr_idx;
    logic [D_WIDTH-1:0] buf0, buf1, buf0_next, buf1_next;

    // Handshake, credit and pop request; pop request is held off while in reset
    always_comb begin
        pop        = (occ != OCC_EMPTY) && m_ready;
        credit     = 2'(occ) + {1'b0, inflight} - {1'b0, pop};
        fifo_rd_en = reset && !fifo_empty && (credit < 2'd2);
        m_valid    = (occ != OCC_EMPTY);
        m_data     = buf0;
    end

    // Occupancy and buffer next state: shift on pop, returning word goes to the tail
    always_comb begin
        occ_next  = occ;
        buf0_next = buf0;
        buf1_next = buf1;
        wr_idx    = (occ == OCC_TWO) || ((occ == OCC_ONE) && !pop);
        case (credit)
            2'd0:    occ_next = OCC_EMPTY;
            2'd1:    occ_next = OCC_ONE;
            default: occ_next = OCC_TWO;
        endcase
        if (pop) begin
            buf0_next = buf1;
        end
        if (inflight) begin
            if (!wr_idx) begin
                buf0_next = fifo_rd_data;
            end else begin
                buf1_next = fifo_rd_data;
            end
        end
    end

    // Occupancy, in-flight flag and data buffer registers
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            occ      <= OCC_EMPTY;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_rd_en;
            buf0     <= buf0_next;
            buf1     <= buf1_next;
        end
    end

`ifdef FIFO_RD_PKT_EN
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PKT_LEN - 1);

    logic [CW-1:0] pkt_cnt, pkt_cnt_next, wr_pos;
    logic          last0, last1, last0_next, last1_next, last_new;

    // Packet position of the head advances on pop; a returning word is tagged
    // with its own position (head position plus its buffer slot)
    always_comb begin
        pkt_cnt_next = pkt_cnt;
        if (pop) begin
            pkt_cnt_next = (pkt_cnt == CNT_MAX) ? '0 : pkt_cnt + CW'(1);
        end
        wr_pos = pkt_cnt_next;
        if (wr_idx) begin
            wr_pos = (pkt_cnt_next == CNT_MAX) ? '0 : pkt_cnt_next + CW'(1);
        end
        last_new   = (wr_pos == CNT_MAX);
        last0_next = last0;
        last1_next = last1;
        if (pop) begin
            last0_next = last1;
        end
        if (inflight) begin
            if (!wr_idx) begin
                last0_next = last_new;
            end else begin
                last1_next = last_new;
            end
        end
    end

    // Packet counter and per-entry last bits
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt <= '0;
            last0   <= 1'b0;
            last1   <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt_next;
            last0   <= last0_next;
            last1   <= last1_next;
        end
    end

    assign m_last = last0 && m_valid;
`else
    // PKT_LEN >= 1, so this is a constant 0
    assign m_last = (PKT_LEN == 0);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed self-checking bench for fifo_rd_stream.
// Contains a small behavioural FIFO read port (1-cycle registered data).
module tb_fifo_rd_stream;

    logic       rd_clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    int         rd_pulses = 0;
    int         empty_viol = 0;

    fifo_rd_stream #(.D_WIDTH(8), .PKT_LEN(4)) dut (
        .rd_clk      (rd_clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: accepted pop returns data on the next cycle
    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 6'd1;
        end
        if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end

    // Pop requests against an empty FIFO
    always @(negedge rd_clk) begin
        if (fifo_rd_en && fifo_empty) empty_viol <= empty_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    logic [7:0] got_d [0:15];
    logic       got_l [0:15];
    int         n_got;
    int         base;
    logic       exp_en [0:5];
    logic       exp_v  [0:5];
    logic [7:0] exp_d  [0:5];

    initial begin
        fifo_rd_data = '0;
        reset   = 1'b0;
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);

        // 1: held in reset with FIFO non-empty and m_ready=1
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk); #1;
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_valid", m_valid, 0);
            check("rst_data",  m_data, 0);
            check("rst_last",  m_last, 0);
        end

        // 2: three-word burst, 2-cycle rd_en-to-valid latency
        exp_en = '{1, 1, 1, 0, 0, 0};
        exp_v  = '{0, 0, 1, 1, 1, 0};
        exp_d  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        @(negedge rd_clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge rd_clk);
            #1;
            check($sformatf("burst_rd_en[%0d]", k), fifo_rd_en, exp_en[k]);
            check($sformatf("burst_valid[%0d]", k), m_valid, exp_v[k]);
            if (exp_v[k]) check($sformatf("burst_data[%0d]", k), m_data, exp_d[k]);
        end

        // 3: back-pressure with 5 words, then drain
        @(negedge rd_clk);
        m_ready = 1'b0;
        base = rd_pulses;
        for (int i = 1; i <= 5; i++) push(8'(i * 8'h11));
        repeat (8) @(negedge rd_clk);
        #1;
        check("bp_pulses", rd_pulses - base, 2);
        check("bp_valid",  m_valid, 1);
        check("bp_data",   m_data, 8'h11);
        check("bp_rd_en",  fifo_rd_en, 0);
        @(negedge rd_clk);
        #1;
        check("bp_hold_data", m_data, 8'h11);
        m_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid && m_ready && n_got < 16) begin
                got_d[n_got] = m_data;
                got_l[n_got] = m_last;
                n_got++;
            end
            @(negedge rd_clk);
        end
        check("drain_count", n_got, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_data[%0d]", i), got_d[i], 8'(8'h11 * (i + 1)));
`ifndef FIFO_RD_PKT_EN
            check($sformatf("drain_last[%0d]", i), got_l[i], 0);
`endif
        end

        // 4: FIFO empty with m_ready=1 for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge rd_clk); #1;
            check("empty_rd_en", fifo_rd_en, 0);
            check("empty_valid", m_valid, 0);
        end

        // 5: reset with one word buffered and one in flight
        @(negedge rd_clk);
        m_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        @(negedge rd_clk);
        @(negedge rd_clk);
        #2;
        check("pre_rst_valid", m_valid, 1);
        reset = 1'b0;
        #1;
        check("async_rd_en", fifo_rd_en, 0);
        check("async_valid", m_valid, 0);
        check("async_data",  m_data, 0);
        check("async_last",  m_last, 0);
        @(negedge rd_clk);
        reset   = 1'b1;
        m_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m_valid && m_ready && n_got < 16) begin
                got_d[n_got] = m_data;
                n_got++;
            end
            @(negedge rd_clk);
        end
        check("post_rst_count", n_got, 2);
        check("post_rst_first", got_d[0], 8'hA3);
        check("post_rst_second", got_d[1], 8'hA4);

`ifdef FIFO_RD_PKT_EN
        // 6: packet markers on words 4 and 8 with ready toggling
        reset = 1'b0;
        @(negedge rd_clk);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        n_got = 0;
        for (int c = 0; c < 40; c++) begin
            m_ready = c[0];
            #1;
            if (m_valid && m_ready && n_got < 16) begin
                got_d[n_got] = m_data;
                got_l[n_got] = m_last;
                n_got++;
            end
            @(negedge rd_clk);
        end
        check("pkt_count", n_got, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pkt_data[%0d]", i), got_d[i], 8'(i + 1));
            check($sformatf("pkt_last[%0d]", i), got_l[i], (i == 3 || i == 7) ? 1 : 0);
        end
`endif

        check("no_pop_when_empty", empty_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
